// File: rtl/wb_regfile_pkg.sv
// Shared types and constants for the writeback/commit stage.
// Register-index width, exception codes and the commit FSM encoding live here.
package wb_regfile_pkg;

   localparam int NREG  = 32;
   localparam int RIDXW = 5;
   localparam int XLEN  = 32;
   localparam int EXPW  = 7;
   localparam int CNTW  = 32;

   typedef logic [RIDXW-1:0] ridx_t;
   typedef logic [XLEN-1:0]  xdata_t;
   typedef logic [EXPW-1:0]  ecode_t;

   // Exception codes raised by execute; zero means the instruction is clean.
   localparam ecode_t ECODE_NONE = 7'h00;
   localparam ecode_t ECODE_ADEF = 7'h08;
   localparam ecode_t ECODE_ALE  = 7'h09;
   localparam ecode_t ECODE_SYS  = 7'h0B;
   localparam ecode_t ECODE_BRK  = 7'h0C;
   localparam ecode_t ECODE_INE  = 7'h0D;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   function automatic logic has_exception(input ecode_t code);
      return code != ECODE_NONE;
   endfunction

endpackage

// File: rtl/wb_regfile_regfile_2w4r.sv
// 32x32 register array with two write ports (lane 1 wins on a clash),
// hardwired r0, and four combinational read ports with write-through bypass.
module regfile_2w4r
   import wb_regfile_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   we0,
   input  ridx_t  waddr0,
   input  xdata_t wdata0,
   input  logic   we1,
   input  ridx_t  waddr1,
   input  xdata_t wdata1,
   input  ridx_t  raddr00,
   input  ridx_t  raddr01,
   input  ridx_t  raddr10,
   input  ridx_t  raddr11,
   output xdata_t rdata00,
   output xdata_t rdata01,
   output xdata_t rdata10,
   output xdata_t rdata11
);

   xdata_t regs_q [NREG];
   xdata_t regs_d [NREG];

   logic wr0_ok;
   logic wr1_ok;

   assign wr0_ok = we0 && (waddr0 != '0);
   assign wr1_ok = we1 && (waddr1 != '0);

   // NOTE: every always_comb output gets a full default first so no latch is inferred.
   always_comb begin
      regs_d = regs_q;
      // NOTE: blocking assignments in combinational logic; the later lane-1 write overrides lane 0.
      if (wr0_ok) regs_d[waddr0] = wdata0;
      if (wr1_ok) regs_d[waddr1] = wdata1;
   end

   // NOTE: the array is reset because software relies on all registers reading zero after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         // NOTE: non-blocking for all sequential state.
         for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      end
   end

   function automatic xdata_t read_port(input ridx_t raddr);
      if (raddr == '0)                      return '0;
      else if (wr1_ok && waddr1 == raddr)   return wdata1;
      else if (wr0_ok && waddr0 == raddr)   return wdata0;
      else                                  return regs_q[raddr];
   endfunction

   assign rdata00 = read_port(raddr00);
   assign rdata01 = read_port(raddr01);
   assign rdata10 = read_port(raddr10);
   assign rdata11 = read_port(raddr11);

endmodule

// File: rtl/wb_regfile.sv
// Writeback/commit stage: gates the two result lanes into the register file,
// captures lane-0 exceptions into a flush handshake and counts retirements.
module wb_regfile
   import wb_regfile_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            en0,
   input  logic [4:0]      addr0,
   input  logic [XLEN-1:0] data0,
   input  logic            en1,
   input  logic [4:0]      addr1,
   input  logic [XLEN-1:0] data1,
   input  logic [EXPW-1:0] exp_in,
   input  logic [31:0]     pc_in,
   input  logic            flush_ack,
   input  logic [4:0]      raddr00,
   input  logic [4:0]      raddr01,
   input  logic [4:0]      raddr10,
   input  logic [4:0]      raddr11,
   output logic [XLEN-1:0] rdata00,
   output logic [XLEN-1:0] rdata01,
   output logic [XLEN-1:0] rdata10,
   output logic [XLEN-1:0] rdata11,
   output logic            excp_flush,
   output logic [31:0]     excp_era,
   output logic [EXPW-1:0] excp_ecode,
   output logic [CNTW-1:0] retired_cnt
);

   state_e          state_q, state_d;
   logic [31:0]     era_q, era_d;
   ecode_t          ecode_q, ecode_d;
   logic [CNTW-1:0] retired_q, retired_d;

   logic       exc_hit;
   logic       commit_ok;
   logic       ret0, ret1;
   logic       we0, we1;
   logic [1:0] retire_inc;

   // Lane 1 is younger than a faulting lane 0, so an exception squashes both lanes.
   assign exc_hit   = (state_q == ST_IDLE) && en0 && has_exception(exp_in);
   assign commit_ok = (state_q == ST_IDLE) && !exc_hit;

   assign ret0 = commit_ok && en0;
   assign ret1 = commit_ok && en1;
   assign we0  = ret0 && (addr0 != '0);
   assign we1  = ret1 && (addr1 != '0);

   // Writes to r0 still retire an instruction even though nothing is stored.
   assign retire_inc = {1'b0, ret0} + {1'b0, ret1};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         era_q     <= '0;
         ecode_q   <= ECODE_NONE;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         era_q     <= era_d;
         ecode_q   <= ecode_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      era_d     = era_q;
      ecode_d   = ecode_q;
      retired_d = retired_q + CNTW'(retire_inc);
      unique case (state_q)
         ST_IDLE: begin
            if (exc_hit) begin
               state_d = ST_FLUSH;
               era_d   = pc_in;
               ecode_d = exp_in;
            end
         end
         ST_FLUSH: begin
            // Further exceptions here are wrong-path; the first capture is kept.
            if (flush_ack) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign excp_flush  = (state_q == ST_FLUSH);
   assign excp_era    = era_q;
   assign excp_ecode  = ecode_q;
   assign retired_cnt = retired_q;

   regfile_2w4r u_rf (
      .clk     (clk),
      .rst     (rst),
      .we0     (we0),
      .waddr0  (addr0),
      .wdata0  (data0),
      .we1     (we1),
      .waddr1  (addr1),
      .wdata1  (data1),
      .raddr00 (raddr00),
      .raddr01 (raddr01),
      .raddr10 (raddr10),
      .raddr11 (raddr11),
      .rdata00 (rdata00),
      .rdata01 (rdata01),
      .rdata10 (rdata10),
      .rdata11 (rdata11)
   );

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback/commit stage directly downstream of the dual-lane execute pipeline.
- Consumes the two registered result lanes (enable, rd address, data) plus lane-0 exception code and PC.
- Commits results into a 32x32 architectural register file and provides four combinational read ports, with write-through bypass, to the register-read stage feeding execute.
- Captures exceptions and runs a small flush handshake with the front end; counts retired instructions.

Parameters:
- NREG, 32, number of architectural registers (fixed; r0 hardwired to zero)
- XLEN, 32, data width
- EXPW, 7, exception code width
- CNTW, 32, retired-instruction counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- en0  in  1  lane-0 result valid
- addr0  in  5  lane-0 destination register
- data0  in  XLEN  lane-0 result
- en1  in  1  lane-1 result valid
- addr1  in  5  lane-1 destination register
- data1  in  XLEN  lane-1 result
- exp_in  in  EXPW  lane-0 exception code, 0 = none
- pc_in  in  32  lane-0 PC
- flush_ack  in  1  front end has redirected; ends the exception flush
- raddr00, raddr01, raddr10, raddr11  in  5 each  read addresses (eu0 rj/rk, eu1 rj/rk)
- rdata00, rdata01, rdata10, rdata11  out  XLEN each  read data, combinational
- excp_flush  out  1  exception flush request, registered, level
- excp_era  out  32  PC of the faulting instruction, registered
- excp_ecode  out  EXPW  captured exception code, registered
- retired_cnt  out  CNTW  committed-instruction count, registered

Behaviour:
- Reset (asynchronous, active-high; `rst`): all 32 registers = 0, FSM = IDLE, excp_flush = 0, excp_era = 0, excp_ecode = 0, retired_cnt = 0. Reset asserted mid-flush returns to IDLE immediately.
- FSM states:
  - IDLE: normal commit.
  - FLUSH: excp_flush = 1; every incoming en0/en1 is dropped as wrong-path.
- Transitions:
  - IDLE -> FLUSH on an edge where en0 = 1 and exp_in != 0.
  - FLUSH -> IDLE on an edge where flush_ack = 1. The first commits are accepted on the following edge.
- Exception edge (IDLE, en0 = 1, exp_in != 0):
  - excp_era <= pc_in; excp_ecode <= exp_in.
  - Neither lane writes; lane 1 is younger and is squashed.
  - retired_cnt is unchanged.
- exp_in != 0 with en0 = 0 is ignored.
- Commit condition: lane k writes when state = IDLE, enk = 1, no exception on this edge, and addrk != 0.
- Write latency: one edge. The value is visible in the array the cycle after the commit edge, and through bypass in the same cycle.
- Same destination on both lanes: lane 1 (younger) wins.
- Writes to r0 are discarded; any read of r0 returns 0.
- Read port value, in priority order:
  1. 0 if the address is 0.
  2. data1 if lane 1 commits this cycle to that address.
  3. data0 if lane 0 commits this cycle to that address.
  4. Otherwise the array value.
- Bypass is gated by the full commit condition, so squashed or flushed writes are never forwarded.
- retired_cnt increments by (number of lanes with enk = 1 that commit or target r0 without exception), in 0..2. It wraps modulo 2^CNTW.
- flush_ack while IDLE: no effect.
- A new exception while in FLUSH is dropped; excp_era and excp_ecode keep the first capture.

Decomposition:
- Shared package holds:
  - exception code width and the ecode constants
  - the FSM state encoding (IDLE = 0, FLUSH = 1)
  - the register-index width
- One natural sub-module: `regfile_2w4r`. It contains the 32x32 array, two write ports with lane-1 priority, r0 = 0, and four bypassed read ports.
- The wrapper holds the FSM, the commit gating and the counter.

Test Plan:
- Reset, then en0 = 1, addr0 = 5, data0 = 0xDEADBEEF -> same cycle rdata00 (raddr00 = 5) = 0xDEADBEEF via bypass; next cycle from the array; retired_cnt = 1.
- en0 and en1 both target r7, data0 = 0x11, data1 = 0x22 -> r7 = 0x22; retired_cnt += 2.
- en1 = 1, addr1 = 0, data1 = 0xFFFFFFFF -> raddr = 0 returns 0; retired_cnt += 1.
- en0 = 1, exp_in = 0x0B, pc_in = 0x1C000040, en1 = 1 to r3 -> next cycle:
  - excp_flush = 1, excp_era = 0x1C000040, excp_ecode = 0x0B
  - r3 unchanged; retired_cnt unchanged
- While in FLUSH: en0 to r4 with 0x55 and a second exception -> both dropped, era unchanged. Then flush_ack = 1 -> excp_flush = 0 next cycle, and a following commit to r4 succeeds.
- Assert rst asynchronously mid-FLUSH -> excp_flush, excp_era and all registers read 0 before the next clk edge.
